vram_ctrl_mem: RTL and testbench

Parametrised successor to the text-controller memory block. It provides one host port (read/write) and one video port (read-only) onto a shared word-addressed VRAM. A bank of CTRL_REGS control registers is mapped directly above the VRAM words. Control registers are double-buffered: host writes land in a shadow copy, which is committed to the active copy on a frame-sync pulse, so video never sees a mid-frame palette or mode change.

---
 rtl/vram_pkg.sv | 32 +++
 rtl/vram_dp_ram.sv | 43 ++++
 rtl/vram_ctrl_mem.sv | 172 +++++++++++++++++
 tb/tb_vram_ctrl_mem.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants, region type and address decoder for the VRAM/control-register memory block.
package vram_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 11;
  localparam int DEF_VRAM_WORDS = 600;
  localparam int DEF_CTRL_REGS  = 8;
  localparam int DEF_CTRL_BASE  = 600;
  localparam int DEF_SHADOW     = 1;

  typedef enum logic [1:0] {
    REG_VRAM,
    REG_CTRL,
    REG_NONE
  } region_t;

  // Limits are passed in so each instance decodes against its own parameters.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [31:0] vram_words,
                                            input logic [31:0] ctrl_base,
                                            input logic [31:0] ctrl_regs);
    region_t r;
    r = REG_NONE;
    if (addr < vram_words) begin
      r = REG_VRAM;
    end else if ((addr >= ctrl_base) && (addr < ctrl_base + ctrl_regs)) begin
      r = REG_CTRL;
    end
    return r;
  endfunction

endpackage

// File: rtl/vram_dp_ram.sv
// Inferred dual-port block RAM: byte-masked read/write port A, read-only port B, read-first.
module vram_dp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 600,
  parameter int IDX_W  = 10
) (
  input  logic                  clk,
  input  logic                  a_en,
  input  logic [DATA_W/8-1:0]   a_we,
  input  logic [IDX_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]     a_din,
  output logic [DATA_W-1:0]     a_q,
  input  logic                  b_en,
  input  logic [IDX_W-1:0]      b_addr,
  output logic [DATA_W-1:0]     b_q
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Non-blocking write plus read in the same edge gives read-first on both ports.
  always_ff @(posedge clk) begin
    if (a_en) begin
      for (int bi = 0; bi < DATA_W / 8; bi++) begin
        if (a_we[bi]) begin
          mem_q[a_addr][bi*8 +: 8] <= a_din[bi*8 +: 8];
        end
      end
      a_rdata_q <= mem_q[a_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (b_en) begin
      b_rdata_q <= mem_q[b_addr];
    end
  end

  assign a_q = a_rdata_q;
  assign b_q = b_rdata_q;

endmodule

// File: rtl/vram_ctrl_mem.sv
// Host/video dual-port VRAM with a double-buffered control register bank mapped above it.
module vram_ctrl_mem
  import vram_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int VRAM_WORDS = DEF_VRAM_WORDS,
  parameter int CTRL_REGS  = DEF_CTRL_REGS,
  parameter int CTRL_BASE  = DEF_CTRL_BASE,
  parameter int SHADOW     = DEF_SHADOW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        a_en,
  input  logic [DATA_W/8-1:0]         a_we,
  input  logic [ADDR_W-1:0]           a_addr,
  input  logic [DATA_W-1:0]           a_din,
  output logic [DATA_W-1:0]           a_dout,
  output logic                        a_valid,
  input  logic                        b_en,
  input  logic [ADDR_W-1:0]           b_addr,
  output logic [DATA_W-1:0]           b_dout,
  output logic                        b_valid,
  input  logic                        frame_sync,
  output logic [CTRL_REGS*DATA_W-1:0] ctrl_out,
  output logic                        commit_pend
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = (VRAM_WORDS > 1) ? $clog2(VRAM_WORDS) : 1;
  localparam int CIDX_W = (CTRL_REGS > 1) ? $clog2(CTRL_REGS) : 1;

  region_t              a_region, b_region;
  logic [CIDX_W-1:0]    a_cidx, b_cidx;
  logic                 a_wr, a_rd, ctrl_wr;
  logic [BE_W-1:0]      ram_we;
  logic [DATA_W-1:0]    ram_a_q, ram_b_q;
  logic [DATA_W-1:0]    shadow_arr [CTRL_REGS];
  logic [DATA_W-1:0]    active_arr [CTRL_REGS];

  logic                 a_valid_q, b_valid_q;
  region_t              a_region_q, b_region_q;
  logic [DATA_W-1:0]    a_ctrl_q, b_ctrl_q;
  logic [DATA_W-1:0]    a_hold_q, b_hold_q;
  logic [DATA_W-1:0]    a_dout_d, b_dout_d;
  logic                 commit_pend_q, commit_pend_d;

  assign a_region = decode_region(32'(a_addr), 32'(VRAM_WORDS), 32'(CTRL_BASE), 32'(CTRL_REGS));
  assign b_region = decode_region(32'(b_addr), 32'(VRAM_WORDS), 32'(CTRL_BASE), 32'(CTRL_REGS));
  assign a_cidx   = CIDX_W'(a_addr - ADDR_W'(CTRL_BASE));
  assign b_cidx   = CIDX_W'(b_addr - ADDR_W'(CTRL_BASE));

  assign a_wr    = a_en && (|a_we);
  assign a_rd    = a_en && !(|a_we);
  assign ctrl_wr = a_wr && (a_region == REG_CTRL);
  assign ram_we  = (a_wr && (a_region == REG_VRAM)) ? a_we : '0;

  vram_dp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (VRAM_WORDS),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk    (clk),
    .a_en   (a_en),
    .a_we   (ram_we),
    .a_addr (IDX_W'(a_addr)),
    .a_din  (a_din),
    .a_q    (ram_a_q),
    .b_en   (b_en),
    .b_addr (IDX_W'(b_addr)),
    .b_q    (ram_b_q)
  );

  // With SHADOW=0 the shadow copy mirrors active, so host reads need no special case.
  for (genvar gi = 0; gi < CTRL_REGS; gi++) begin : g_ctrl
    logic [DATA_W-1:0] shadow_q, active_q, merged_d;
    logic              hit;

    assign hit = ctrl_wr && (a_cidx == CIDX_W'(gi));

    always_comb begin
      merged_d = shadow_q;
      for (int bi = 0; bi < BE_W; bi++) begin
        if (a_we[bi]) merged_d[bi*8 +: 8] = a_din[bi*8 +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        if (hit) shadow_q <= merged_d;
        if (SHADOW != 0) begin
          if (frame_sync) active_q <= shadow_q;
        end else if (hit) begin
          active_q <= merged_d;
        end
      end
    end

    assign shadow_arr[gi]                 = shadow_q;
    assign active_arr[gi]                 = active_q;
    assign ctrl_out[gi*DATA_W +: DATA_W]  = active_q;
  end

  always_comb begin
    commit_pend_d = commit_pend_q;
    if (SHADOW != 0) begin
      if (ctrl_wr)         commit_pend_d = 1'b1;
      else if (frame_sync) commit_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q     <= 1'b0;
      b_valid_q     <= 1'b0;
      a_region_q    <= REG_NONE;
      b_region_q    <= REG_NONE;
      a_ctrl_q      <= '0;
      b_ctrl_q      <= '0;
      a_hold_q      <= '0;
      b_hold_q      <= '0;
      commit_pend_q <= 1'b0;
    end else begin
      a_valid_q     <= a_rd;
      b_valid_q     <= b_en;
      a_hold_q      <= a_dout_d;
      b_hold_q      <= b_dout_d;
      commit_pend_q <= commit_pend_d;
      if (a_rd) begin
        a_region_q <= a_region;
        a_ctrl_q   <= shadow_arr[a_cidx];
      end
      if (b_en) begin
        b_region_q <= b_region;
        b_ctrl_q   <= active_arr[b_cidx];
      end
    end
  end

  always_comb begin
    a_dout_d = a_hold_q;
    if (a_valid_q) begin
      case (a_region_q)
        REG_VRAM: a_dout_d = ram_a_q;
        REG_CTRL: a_dout_d = a_ctrl_q;
        default:  a_dout_d = '0;
      endcase
    end
  end

  always_comb begin
    b_dout_d = b_hold_q;
    if (b_valid_q) begin
      case (b_region_q)
        REG_VRAM: b_dout_d = ram_b_q;
        REG_CTRL: b_dout_d = b_ctrl_q;
        default:  b_dout_d = '0;
      endcase
    end
  end

  // Reset masks a result already on the port, so a read caught by reset never shows valid.
  assign a_dout      = reset ? '0 : a_dout_d;
  assign b_dout      = reset ? '0 : b_dout_d;
  assign a_valid     = a_valid_q && !reset;
  assign b_valid     = b_valid_q && !reset;
  assign commit_pend = commit_pend_q;

endmodule

// File: tb/tb_vram_ctrl_mem.sv
// Table-driven check of vram_ctrl_mem: VRAM access, byte masks, shadow commit, collisions, reset.
module tb_vram_ctrl_mem;

  logic         clk;
  logic         reset;
  logic         a_en;
  logic [3:0]   a_we;
  logic [10:0]  a_addr;
  logic [31:0]  a_din;
  logic [31:0]  a_dout;
  logic         a_valid;
  logic         b_en;
  logic [10:0]  b_addr;
  logic [31:0]  b_dout;
  logic         b_valid;
  logic         frame_sync;
  logic [255:0] ctrl_out;
  logic         commit_pend;

  int errors = 0;
  int checks = 0;

  vram_ctrl_mem dut (
    .clk         (clk),
    .reset       (reset),
    .a_en        (a_en),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_din       (a_din),
    .a_dout      (a_dout),
    .a_valid     (a_valid),
    .b_en        (b_en),
    .b_addr      (b_addr),
    .b_dout      (b_dout),
    .b_valid     (b_valid),
    .frame_sync  (frame_sync),
    .ctrl_out    (ctrl_out),
    .commit_pend (commit_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        a_en;
    logic [3:0]  a_we;
    logic [10:0] a_addr;
    logic [31:0] a_din;
    logic        b_en;
    logic [10:0] b_addr;
    logic        fs;
    logic        exp_av;
    logic [31:0] exp_a;
    logic        exp_bv;
    logic [31:0] exp_b;
    logic [31:0] exp_c0;
    logic [31:0] exp_c1;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic en, input logic [3:0] we, input logic [10:0] ad,
                     input logic [31:0] din, input logic ben, input logic [10:0] bad, input logic fs,
                     input logic av, input logic [31:0] ea, input logic bv, input logic [31:0] eb,
                     input logic [31:0] c0, input logic [31:0] c1, input logic pend);
    vec_t v;
    v.name = nm; v.a_en = en; v.a_we = we; v.a_addr = ad; v.a_din = din;
    v.b_en = ben; v.b_addr = bad; v.fs = fs;
    v.exp_av = av; v.exp_a = ea; v.exp_bv = bv; v.exp_b = eb;
    v.exp_c0 = c0; v.exp_c1 = c1; v.exp_pend = pend;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    a_en = 1'b0; a_we = 4'h0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_addr = '0; frame_sync = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    //   name          a_en we    addr  din           b_en baddr fs | av a_dout       bv b_dout       ctrl0 ctrl1 pend
    add("wr5",         1, 4'hF,  5,   32'hDEADBEEF, 0, 0,   0,   0, 32'h0,        0, 32'h0,        0,    0,    0);
    add("rd5",         1, 4'h0,  5,   32'h0,        1, 5,   0,   1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0,    0,    0);
    add("wr10",        1, 4'hF,  10,  32'h11223344, 0, 0,   0,   0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0,    0,    0);
    add("wr10_mask",   1, 4'h5,  10,  32'hAABBCCDD, 0, 0,   0,   0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0,    0,    0);
    add("rd10",        1, 4'h0,  10,  32'h0,        0, 0,   0,   1, 32'h11BB33DD, 0, 32'hDEADBEEF, 0,    0,    0);
    add("rd5_b2b",     1, 4'h0,  5,   32'h0,        0, 0,   0,   1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0,    0,    0);
    add("idle_hold",   0, 4'h0,  0,   32'h0,        0, 0,   0,   0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0,    0,    0);
    add("wr600",       1, 4'hF,  600, 32'h7,        0, 0,   0,   0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0,    0,    1);
    add("rd600",       1, 4'h0,  600, 32'h0,        1, 600, 0,   1, 32'h7,        1, 32'h0,        0,    0,    1);
    add("fs_commit",   0, 4'h0,  0,   32'h0,        0, 0,   1,   0, 32'h7,        0, 32'h0,        7,    0,    0);
    add("vid600",      0, 4'h0,  0,   32'h0,        1, 600, 0,   0, 32'h7,        1, 32'h7,        7,    0,    0);
    add("wr601_3",     1, 4'hF,  601, 32'h3,        0, 0,   0,   0, 32'h7,        0, 32'h7,        7,    0,    1);
    add("wr601_5_fs",  1, 4'hF,  601, 32'h5,        0, 0,   1,   0, 32'h7,        0, 32'h7,        7,    3,    1);
    add("rd601",       1, 4'h0,  601, 32'h0,        0, 0,   0,   1, 32'h5,        0, 32'h7,        7,    3,    1);
    add("fs_commit2",  0, 4'h0,  0,   32'h0,        0, 0,   1,   0, 32'h5,        0, 32'h7,        7,    5,    0);
    add("wr20_1",      1, 4'hF,  20,  32'h1,        0, 0,   0,   0, 32'h5,        0, 32'h7,        7,    5,    0);
    add("wr20_2_coll", 1, 4'hF,  20,  32'h2,        1, 20,  0,   0, 32'h5,        1, 32'h1,        7,    5,    0);
    add("vid20",       0, 4'h0,  0,   32'h0,        1, 20,  0,   0, 32'h5,        1, 32'h2,        7,    5,    0);
    add("wr700",       1, 4'hF,  700, 32'hFFFFFFFF, 0, 0,   0,   0, 32'h5,        0, 32'h2,        7,    5,    0);
    add("rd700",       1, 4'h0,  700, 32'h0,        1, 700, 0,   1, 32'h0,        1, 32'h0,        7,    5,    0);
    add("wr602_byte1", 1, 4'h2,  602, 32'h1234AB78, 0, 0,   0,   0, 32'h0,        0, 32'h0,        7,    5,    1);
    add("rd602",       1, 4'h0,  602, 32'h0,        1, 602, 0,   1, 32'h0000AB00, 1, 32'h0,        7,    5,    1);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_a_valid", 32'(a_valid), 32'h0);
    check("rst_b_valid", 32'(b_valid), 32'h0);
    check("rst_a_dout", a_dout, 32'h0);
    check("rst_b_dout", b_dout, 32'h0);
    check("rst_pend", 32'(commit_pend), 32'h0);
    check("rst_ctrl_any", 32'(|ctrl_out), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      a_en = vecs[i].a_en; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_din = vecs[i].a_din;
      b_en = vecs[i].b_en; b_addr = vecs[i].b_addr; frame_sync = vecs[i].fs;
      @(posedge clk);
      #1;
      idle_inputs();
      check({vecs[i].name, ".a_valid"}, 32'(a_valid), 32'(vecs[i].exp_av));
      check({vecs[i].name, ".a_dout"}, a_dout, vecs[i].exp_a);
      check({vecs[i].name, ".b_valid"}, 32'(b_valid), 32'(vecs[i].exp_bv));
      check({vecs[i].name, ".b_dout"}, b_dout, vecs[i].exp_b);
      check({vecs[i].name, ".ctrl0"}, ctrl_out[31:0], vecs[i].exp_c0);
      check({vecs[i].name, ".ctrl1"}, ctrl_out[63:32], vecs[i].exp_c1);
      check({vecs[i].name, ".pend"}, 32'(commit_pend), 32'(vecs[i].exp_pend));
      $display("txn %0d %s a_valid=%0b a_dout=%h b_valid=%0b b_dout=%h pend=%0b",
               i, vecs[i].name, a_valid, a_dout, b_valid, b_dout, commit_pend);
    end

    // Read requests in flight when reset arrives: no valid pulse, everything cleared.
    a_en = 1'b1; a_we = 4'h0; a_addr = 11'd10; b_en = 1'b1; b_addr = 11'd5;
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rstdrop_a_valid", 32'(a_valid), 32'h0);
    check("rstdrop_b_valid", 32'(b_valid), 32'h0);
    check("rstdrop_a_dout", a_dout, 32'h0);
    check("rstdrop_b_dout", b_dout, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("postrst_a_valid", 32'(a_valid), 32'h0);
    check("postrst_b_valid", 32'(b_valid), 32'h0);
    check("postrst_a_dout", a_dout, 32'h0);
    check("postrst_b_dout", b_dout, 32'h0);
    check("postrst_pend", 32'(commit_pend), 32'h0);
    check("postrst_ctrl_any", 32'(|ctrl_out), 32'h0);
    $display("txn reset_drop a_valid=%0b b_valid=%0b pend=%0b", a_valid, b_valid, commit_pend);

    // RAM survives reset; a commit now moves the cleared shadow (0) into active.
    a_en = 1'b1; a_we = 4'h0; a_addr = 11'd5; frame_sync = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    check("ram_kept.a_valid", 32'(a_valid), 32'h1);
    check("ram_kept.a_dout", a_dout, 32'hDEADBEEF);
    check("ram_kept.ctrl0", ctrl_out[31:0], 32'h0);
    $display("txn ram_kept a_valid=%0b a_dout=%h", a_valid, a_dout);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
